// File: rtl/clock_pkg.sv
// Purpose: shared BCD helpers and field limits for the clock core and the time setter.
// Latency: pure functions and constants only; no state.
// Backpressure: none.
package clock_pkg;

  localparam logic [7:0] BCD_MAX_SEC = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HR  = 8'h23;

  // One-step BCD increment that wraps to 00 once the field limit is reached.
  // Anything at or above the limit also wraps, so a corrupted value self-heals.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val >= max) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'h0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // True when both nibbles are decimal digits and the value is within the field limit.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Purpose: one BCD time field (ss, mm or hh) that wraps at MAX and reports a carry.
// Latency: value updates on the clock edge after inc/load; carry is combinational from inc.
// Backpressure: none; load always wins over inc.
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] val_o,
  output logic       carry_o
);

  logic [7:0] val_q;
  logic [7:0] val_d;

  // Next value: a load replaces the field outright, otherwise step on inc.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (inc_i) begin
      val_d = bcd_inc(val_q, MAX);
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o   = val_q;
  assign carry_o = inc_i && (val_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// Purpose: 1 Hz prescaler plus BCD HH:MM:SS timekeeping with freeze/load from the setter.
// Latency: time, sec_tick and day_wrap change one cycle after the prescaler tick or load.
// Backpressure: none; ticks during set_en are dropped, set_load always takes priority.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int         CLK_HZ = 50_000_000,
  parameter logic [7:0] RST_HH = 8'h12,
  parameter logic [7:0] RST_MM = 8'h00,
  parameter logic [7:0] RST_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       set_load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] cur_hh,
  output logic [7:0] cur_mm,
  output logic [7:0] cur_ss,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       blink_phase
);

  localparam int              PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          sec_tick_q;
  logic          day_wrap_q;
  logic          day_wrap_d;

  logic          tick;
  logic          advance;
  logic          ss_carry;
  logic          mm_carry;
  logic          hh_carry;
  logic [7:0]    load_hh;
  logic [7:0]    load_mm;
  logic [7:0]    load_ss;

  assign tick    = (presc_q == PRESC_LAST);
  // Load owns the cycle it happens in, so a coincident tick must not also advance.
  assign advance = tick && !set_en && !set_load;

  // Out-of-range or non-decimal fields from the setter collapse to 00.
  assign load_hh = bcd_valid(set_hh, BCD_MAX_HR)  ? set_hh : 8'h00;
  assign load_mm = bcd_valid(set_mm, BCD_MAX_MIN) ? set_mm : 8'h00;
  assign load_ss = bcd_valid(set_ss, BCD_MAX_SEC) ? set_ss : 8'h00;

  // Prescaler next state: restart on load so the first second after a set is full length.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (set_load || tick) begin
      presc_d = '0;
    end
  end

  // Day wrap is just the hour field's carry out of 23.
  always_comb begin
    day_wrap_d = hh_carry;
  end

  // Prescaler and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= tick;
      day_wrap_q <= day_wrap_d;
    end
  end

  bcd_wrap_counter #(.MAX(BCD_MAX_SEC), .RST_VAL(RST_SS)) u_ss (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (advance),
    .load_i     (set_load),
    .load_val_i (load_ss),
    .val_o      (cur_ss),
    .carry_o    (ss_carry)
  );

  bcd_wrap_counter #(.MAX(BCD_MAX_MIN), .RST_VAL(RST_MM)) u_mm (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (ss_carry),
    .load_i     (set_load),
    .load_val_i (load_mm),
    .val_o      (cur_mm),
    .carry_o    (mm_carry)
  );

  bcd_wrap_counter #(.MAX(BCD_MAX_HR), .RST_VAL(RST_HH)) u_hh (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (mm_carry),
    .load_i     (set_load),
    .load_val_i (load_hh),
    .val_o      (cur_hh),
    .carry_o    (hh_carry)
  );

  assign sec_tick    = sec_tick_q;
  assign day_wrap    = day_wrap_q;
  assign blink_phase = (presc_q < PRESC_HALF);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Purpose: self-checking bench for bcd_time_counter with a seconds-of-day reference model.
// Latency: outputs compared every falling edge; directed checks pin key moments.
// Backpressure: not applicable.
module tb_bcd_time_counter;

  localparam int HZ = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_en   = 1'b0;
  logic       set_load = 1'b0;
  logic [7:0] set_hh   = 8'h00;
  logic [7:0] set_mm   = 8'h00;
  logic [7:0] set_ss   = 8'h00;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       sec_tick;
  logic       day_wrap;
  logic       blink_phase;

  int errors = 0;
  int checks = 0;

  bcd_time_counter #(
    .CLK_HZ(HZ), .RST_HH(8'h12), .RST_MM(8'h00), .RST_SS(8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (set_en),
    .set_load    (set_load),
    .set_hh      (set_hh),
    .set_mm      (set_mm),
    .set_ss      (set_ss),
    .cur_hh      (cur_hh),
    .cur_mm      (cur_mm),
    .cur_ss      (cur_ss),
    .sec_tick    (sec_tick),
    .day_wrap    (day_wrap),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: time as plain seconds of day ----------------
  int m_t  = 12 * 3600;
  int m_ph = 0;
  bit m_st = 1'b0;
  bit m_dw = 1'b0;

  function automatic int field_dec(input logic [7:0] v, input int limit);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    d  = hi * 10 + lo;
    if (hi > 9 || lo > 9 || d > limit) d = 0;
    return d;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 12 * 3600; m_ph = 0; m_st = 1'b0; m_dw = 1'b0;
    end else begin
      m_st = (m_ph == HZ - 1);
      m_dw = 1'b0;
      if (set_load) begin
        m_t  = field_dec(set_hh, 23) * 3600 + field_dec(set_mm, 59) * 60 + field_dec(set_ss, 59);
        m_ph = 0;
      end else begin
        if (m_st && !set_en) begin
          if (m_t == 86399) m_dw = 1'b1;
          m_t = (m_t + 1) % 86400;
        end
        m_ph = (m_ph + 1) % HZ;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_hh",    int'(cur_hh),      int'(to_bcd(m_t / 3600)));
    chk("cyc_mm",    int'(cur_mm),      int'(to_bcd((m_t / 60) % 60)));
    chk("cyc_ss",    int'(cur_ss),      int'(to_bcd(m_t % 60)));
    chk("cyc_tick",  int'(sec_tick),    int'(m_st));
    chk("cyc_wrap",  int'(day_wrap),    int'(m_dw));
    chk("cyc_blink", int'(blink_phase), int'(m_ph < HZ / 2));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    chk({name, "_hh"}, int'(cur_hh), int'(h));
    chk({name, "_mm"}, int'(cur_mm), int'(m));
    chk({name, "_ss"}, int'(cur_ss), int'(s));
  endtask

  // Drive a one-cycle load at the current falling edge; returns at the next falling edge.
  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic en);
    set_hh = h; set_mm = m; set_ss = s; set_en = en; set_load = 1'b1;
    step(1);
    set_load = 1'b0;
  endtask

  int ticks;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(2);
    chk_time("rst", 8'h12, 8'h00, 8'h00);
    chk("rst_blink", int'(blink_phase), 1);
    chk("rst_tick",  int'(sec_tick), 0);
    chk("rst_wrap",  int'(day_wrap), 0);
    rst_n = 1'b1;

    // First second after release.
    step(9);
    chk("pre_ss",    int'(cur_ss), 8'h00);
    chk("pre_blink", int'(blink_phase), 0);
    step(1);
    chk("first_ss",   int'(cur_ss), 8'h01);
    chk("first_tick", int'(sec_tick), 1);

    // Day rollover.
    do_load(8'h23, 8'h59, 8'h58, 1'b1);
    set_en = 1'b0;
    step(10);
    chk_time("pre_wrap", 8'h23, 8'h59, 8'h59);
    step(10);
    chk_time("wrap", 8'h00, 8'h00, 8'h00);
    chk("wrap_pulse", int'(day_wrap), 1);
    step(1);
    chk("wrap_once", int'(day_wrap), 0);

    // Hold while setting.
    do_load(8'h08, 8'h30, 8'h15, 1'b1);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (sec_tick) ticks++;
    end
    chk_time("hold", 8'h08, 8'h30, 8'h15);
    chk("hold_ticks", ticks, 5);

    // Sanitising of illegal fields.
    do_load(8'h24, 8'h7A, 8'h45, 1'b1);
    chk_time("sanit", 8'h00, 8'h00, 8'h45);
    set_en = 1'b0;

    // Load coinciding with tick, set_en low.
    step(9);
    do_load(8'h10, 8'h09, 8'h59, 1'b0);
    chk_time("ld_tick", 8'h10, 8'h09, 8'h59);
    chk("ld_tick_st", int'(sec_tick), 1);
    step(9);
    chk_time("ld_hold", 8'h10, 8'h09, 8'h59);
    step(1);
    chk_time("ld_adv", 8'h10, 8'h10, 8'h00);

    // Asynchronous reset mid-second.
    do_load(8'h17, 8'h42, 8'h33, 1'b0);
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk_time("arst", 8'h12, 8'h00, 8'h00);
    chk("arst_blink", int'(blink_phase), 1);
    chk("arst_wrap",  int'(day_wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(9);
    chk_time("arst_hold", 8'h12, 8'h00, 8'h00);
    step(1);
    chk_time("arst_adv", 8'h12, 8'h00, 8'h01);
    chk("arst_tick", int'(sec_tick), 1);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
